// File: rtl/fb_port_scheduler.sv
// rtl/fb_port_scheduler.sv - single-port frame-buffer arbiter: fixed display read slots, writer fills the rest.
// Optional feature macro: FB_DOUBLE_BUFFER_EN (two banks with vblank swap); default is a single bank.
module fb_port_scheduler #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int HA_STA = 160,
    parameter int DW     = 8,
    parameter int AW     = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_stb,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          active,
    input  logic          animate,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_data
);

    typedef enum logic [1:0] {IDLE, DISP_RD, CAPTURE, WRITE} state_t;
    state_t state;

    logic [9:0]    x_rel;
    logic          in_win;
    logic [AW-1:0] row_ext;
    logic [AW-1:0] col_ext;
    logic [AW-1:0] rd_idx;
    logic          slot_due;
    logic          take;
    logic          wr_in_range;
    logic          swap_pending;
    logic          swap_fire;
    logic [1:0]    blank_d;
    logic          rd_bank;
    logic          wr_bank;

    assign x_rel  = x - 10'(HA_STA);
    assign in_win = active && (x_rel < 10'(2 * IMG_W)) && (y < 10'(2 * IMG_H));

    // 2x upscale: halve both coordinates, then row*320 as row*256 + row*64
    assign row_ext = AW'(y >> 1);
    assign col_ext = AW'(x_rel >> 1);
    assign rd_idx  = (row_ext << 8) + (row_ext << 6) + col_ext;

    assign slot_due    = pix_stb && in_win;
    assign wr_ready    = !reset && (state == IDLE || state == WRITE) && !slot_due;
    assign take        = wr_valid && wr_ready;
    assign wr_in_range = wr_addr < AW'(IMG_W * IMG_H);
    assign swap_fire   = animate && pix_stb && (swap_pending || swap_req);

`ifdef FB_DOUBLE_BUFFER_EN
    logic front;

    always_ff @(posedge clk) begin
        if (reset)
            front <= 1'b0;
        else if (swap_fire)
            front <= ~front;
    end

    assign rd_bank = front;
    assign wr_bank = ~front;
`else
    assign rd_bank = 1'b0;
    assign wr_bank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            pix_data     <= '0;
            swap_ack     <= 1'b0;
            swap_pending <= 1'b0;
            blank_d      <= '0;
        end else begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            swap_ack     <= swap_fire;
            swap_pending <= swap_fire ? 1'b0 : (swap_pending || swap_req);
            // out-of-window ticks blank the pixel at the same latency a read would land
            blank_d      <= {blank_d[0], pix_stb && !in_win};
            if (blank_d[1])
                pix_data <= '0;

            case (state)
                IDLE, WRITE: begin
                    if (slot_due) begin
                        state    <= DISP_RD;
                        mem_en   <= 1'b1;
                        mem_addr <= {rd_bank, rd_idx};
                    end else if (take) begin
                        state     <= WRITE;
                        mem_en    <= wr_in_range;
                        mem_we    <= wr_in_range;
                        mem_addr  <= {wr_bank, wr_addr};
                        mem_wdata <= wr_data;
                    end else begin
                        state <= IDLE;
                    end
                end
                DISP_RD: state <= CAPTURE;
                CAPTURE: begin
                    state    <= IDLE;
                    pix_data <= mem_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_port_scheduler.sv
// tb/tb_fb_port_scheduler.sv - directed self-checking bench for fb_port_scheduler with a behavioural RAM.
`timescale 1ns/1ps
module tb_fb_port_scheduler;

    localparam int AW = 17;
    localparam int DW = 8;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_stb;
    logic [9:0]    x;
    logic [9:0]    y;
    logic          active;
    logic          animate;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;
    logic          swap_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fb_port_scheduler dut (
        .clk(clk), .reset(reset), .pix_stb(pix_stb), .x(x), .y(y),
        .active(active), .animate(animate), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_data(pix_data)
    );

    // RAM preloaded with (address low byte ^ 0x5A); reads return data one clk after mem_en
    logic [DW-1:0] ram [0:(1<<(AW+1))-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << (AW + 1)); i++)
            ram[i] <= 8'(i) ^ 8'h5A;

        reset = 1'b1; pix_stb = 1'b0; x = 10'd0; y = 10'd500; active = 1'b0;
        animate = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
        step(); step();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_swap_ack", swap_ack, 0);
        check("rst_wr_ready", wr_ready, 0);

        // reset arriving while a write is on the bus
        reset = 1'b0; wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 8'h99;
        step();
        check("pre_rst_write", {mem_en, mem_we}, 2'b11);
        reset = 1'b1;
        step();
        check("midrst_mem_en", mem_en, 0);
        check("midrst_wr_ready", wr_ready, 0);
        check("midrst_pix_data", pix_data, 0);
        reset = 1'b0; wr_valid = 1'b0;
        step();

        // blanking burst: one write per clk
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 8'(8'h30 + i);
            #1 check("burst_ready", wr_ready, 1);
            step();
            check("burst_en_we", {mem_en, mem_we}, 2'b11);
            check("burst_addr", mem_addr, {DB, AW'(i)});
            check("burst_data", mem_wdata, 8'h30 + i);
        end
        wr_valid = 1'b0;
        step();
        check("burst_end", mem_en, 0);

        // display slot pre-empts a waiting writer
        active = 1'b1; x = 10'd160; y = 10'd0; pix_stb = 1'b1;
        wr_valid = 1'b1; wr_addr = 17'd10; wr_data = 8'h77;
        #1 check("slot_ready_low", wr_ready, 0);
        step();
        pix_stb = 1'b0;
        check("rd_en_we", {mem_en, mem_we}, 2'b10);
        check("rd_addr_0", mem_addr, 18'd0);
        #1 check("rd_ready_low", wr_ready, 0);
        step();
        check("cap_mem_en", mem_en, 0);
        step();
        check("rd_pix_0", pix_data, DB ? 8'h5A : 8'h30);
        #1 check("resume_ready", wr_ready, 1);
        step();
        check("resume_write", {mem_en, mem_we}, 2'b11);
        check("resume_addr", mem_addr, {DB, 17'd10});
        wr_valid = 1'b0;
        step();

        // x=162,y=3 -> index 1*320+1 = 321; ram byte 0x41^0x5A = 0x1B
        x = 10'd162; y = 10'd3; pix_stb = 1'b1;
        step();
        pix_stb = 1'b0;
        check("rd_addr_321", mem_addr, 18'd321);
        step(); step();
        check("rd_pix_321", pix_data, 8'h1B);

        // last stored pixel: 239*320+319 = 76799 (0x12BFF); 0xFF^0x5A = 0xA5
        x = 10'd799; y = 10'd479; pix_stb = 1'b1;
        step();
        pix_stb = 1'b0;
        check("rd_addr_last", mem_addr, 18'd76799);
        step(); step();
        check("rd_pix_last", pix_data, 8'hA5);

        // x=800 is one past the window even with active high
        x = 10'd800; y = 10'd3; pix_stb = 1'b1;
        step();
        pix_stb = 1'b0;
        check("outwin_no_read", mem_en, 0);
        step();
        check("outwin_hold", pix_data, 8'hA5);
        step();
        check("outwin_zero", pix_data, 0);

        // out-of-range write is accepted but dropped
        active = 1'b0; x = 10'd0; y = 10'd500; wr_valid = 1'b1; wr_addr = 17'd76800; wr_data = 8'hEE;
        #1 check("drop_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        check("drop_no_en", mem_en, 0);
        step();

        // single swap request, then the animate tick
        y = 10'd100; swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("swap_wait", swap_ack, 0);
        step();
        y = 10'd479; animate = 1'b1; pix_stb = 1'b1;
        step();
        animate = 1'b0; pix_stb = 1'b0;
        check("swap_ack", swap_ack, 1);
        step();
        check("swap_ack_pulse", swap_ack, 0);

        active = 1'b1; x = 10'd160; y = 10'd0; pix_stb = 1'b1;
        step();
        pix_stb = 1'b0;
        check("front_after_swap", mem_addr, {DB, 17'd0});
        step(); step();
        active = 1'b0; y = 10'd500; wr_valid = 1'b1; wr_addr = 17'd3; wr_data = 8'h11;
        step();
        wr_valid = 1'b0;
        check("back_after_swap", mem_addr, {1'b0, 17'd3});
        step();

        // two requests in one frame give one swap
        y = 10'd100; swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0; y = 10'd479; animate = 1'b1; pix_stb = 1'b1;
        step();
        animate = 1'b0; pix_stb = 1'b0;
        check("dbl_swap_ack", swap_ack, 1);
        step();
        active = 1'b1; x = 10'd160; y = 10'd0; pix_stb = 1'b1;
        step();
        pix_stb = 1'b0;
        check("dbl_front", mem_addr, 18'd0);
        step(); step();
        active = 1'b0;

        // animate with nothing pending
        y = 10'd479; animate = 1'b1; pix_stb = 1'b1;
        step();
        animate = 1'b0; pix_stb = 1'b0;
        check("no_pending_ack", swap_ack, 0);
        step();

        // request on the animate clk itself
        swap_req = 1'b1; animate = 1'b1; pix_stb = 1'b1;
        step();
        swap_req = 1'b0; animate = 1'b0; pix_stb = 1'b0;
        check("same_clk_ack", swap_ack, 1);
        step();
        active = 1'b1; x = 10'd160; y = 10'd0; pix_stb = 1'b1;
        step();
        pix_stb = 1'b0;
        check("same_clk_front", mem_addr, {DB, 17'd0});
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
